sbox_arbiter: RTL and testbench
===============================

# sbox_arbiter

Single-cycle-per-access arbiter sharing the four S-box SRAM banks (128 × 64-bit words each, 32-bit entries selected by half bit) among three requesters: the Blowfish round-function lookup path, the key-expansion write path, and a host debug read port. It sits between the bcrypt datapath/sequencer and the SRAM macros. It owns the wordline address lanes, the write enables and write data. It buffers writes in a 2-entry FIFO, enforces read-after-write ordering, and bounds starvation of the lower-priority requesters.

## Interface
- STARVE_MAX, 8: consecutive denied cycles before a waiting write or host read is forced through.
- clk  in  1  single clock, all state on posedge.
- rst_l  in  1  asynchronous, active-low reset.
- rd_req  in  1  round lookup request.
- rd_addr  in  32  byte k = S-box k index; [8k+7:8k+1] word, [8k] half.
- rd_gnt  out  1  lookup accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid (1-cycle pulse).
- rd_data  out  128  {S3,S2,S1,S0}, 32 bits each.
- wr_req  in  1  write push request.
- wr_bank  in  2  target bank.
- wr_addr  in  7  target word.
- wr_data  in  64  {L,R} word.
- wr_rdy  out  1  FIFO not full; a push occurs when wr_req & wr_rdy.
- host_req  in  1  debug read request.
- host_addr  in  10  [9:8] bank, [7:1] word, [0] half.
- host_gnt  out  1  host read accepted this cycle (combinational).
- host_valid  out  1  host_data valid (1-cycle pulse).
- host_data  out  32  selected entry.
- sram_addr  out  28  {a3,a2,a1,a0}, 7 bits per bank.
- sram_we  out  4  per-bank write enable.
- sram_wdata  out  64  write data, shared by all banks.
- sram_q  in  256  {q3,q2,q1,q0}, valid the cycle after the address is presented.
- busy  out  1  FIFO non-empty, or a read is in flight.

## Operation
- Exactly one access is granted per cycle. Priority:
  1. Forced write: FIFO non-empty and wr_wait == STARVE_MAX.
  2. Forced host read: host_req and host_wait == STARVE_MAX.
  3. Round read: rd_req and no hazard.
  4. Write: FIFO non-empty.
  5. Host read.
- Hazard: any valid FIFO entry whose bank b and word match word field of rd_addr byte b. While a hazard exists, rd_gnt = 0 and priority 4 drains the FIFO. Hazard checks cover registered FIFO entries only. A push in the same cycle as a round read does not block it; that read returns pre-write data.
- Write issue: FIFO head drives sram_addr lane b and sram_wdata, with sram_we[b] = 1. Head pops the same cycle.
- Round read: sram_addr lane k = rd_addr[8k+7:8k+1]. Half bits are registered. Lane k of rd_data = half ? q_k[63:32] : q_k[31:0].
- Host read: only the selected lane is driven; half select as for round reads.
- Idle, non-driven and non-written lanes: sram_addr = 0, sram_we = 0, sram_wdata = 0.
- FIFO: depth 2, in order. Push and pop in the same cycle leave the count unchanged. wr_rdy = (count < 2), decoded from registered count.
- wr_wait: +1 each cycle the FIFO is non-empty and no write is granted. Saturates at STARVE_MAX. Clears on write grant or when the FIFO is empty.
- host_wait: +1 each cycle host_req & ~host_gnt. Saturates. Clears on host grant or when host_req is low.
- If both are forced in the same cycle, the write wins and host_wait holds at STARVE_MAX.

## Timing
- Reset values (async): rd_gnt, rd_valid, rd_data, host_gnt, host_valid, host_data, sram_addr, sram_we, sram_wdata, busy = 0. wr_rdy = 1. FIFO empty. Counters 0.
- Grant in cycle t: SRAM address at t, sram_q at t+1, rd_valid/host_valid with data at t+2.
- Data outputs hold their value between pulses.
- Back-to-back round reads: one per cycle, fully pipelined.
- Write latency: a pushed entry is issuable no earlier than the cycle after the push.
- Reset mid-operation clears the FIFO and the read pipeline. No valid pulse follows reset deassertion.
- busy = (count != 0) | any read stage in flight.

## Test plan
- Reset, then idle: all outputs at their reset values. wr_rdy = 1, busy = 0.
- Round read: sram_q lanes preloaded so q_k = {32'hA000000k, 32'hB000000k}; rd_req with rd_addr = 0x07050301. Required: rd_gnt = 1 in the same cycle; sram_addr = {7'd3, 7'd2, 7'd1, 7'd0}; rd_valid 2 cycles later with rd_data = {A3, A2, A1, A0}.
- Starvation: rd_req held high with non-hazard addresses; one write pushed in cycle 0. Required: rd_gnt = 1 in cycles 1–8; in cycle 9 the write issues, rd_gnt = 0, sram_we = 4'b0001 for bank 0.
- RAW hazard: push bank 2 / word 5 / data 0x1122334455667788; the next cycle, rd_req with byte 2 = 0x0A. Required: rd_gnt = 0 while the entry is queued and the write issues first; on the following cycle rd_gnt = 1 and S2 = 0x55667788.
- Host read on an idle bus: host_addr = 0x305. Required: host_gnt = 1; sram_addr lane 3 = 2, other lanes 0; host_data = q3[63:32] 2 cycles later.
- Full FIFO plus reset: push 2 writes while rd_req is held. Required: wr_rdy = 0. Asserting rst_l low with a read in flight gives wr_rdy = 1, busy = 0, and no rd_valid pulse after release.

Source files
------------

// File: rtl/sbox_arbiter.sv
// sbox_arbiter: one S-box SRAM access per cycle shared by round reads, FIFO'd key writes and host reads.
// Latency: grant and SRAM address in the same cycle, read data two cycles after grant; writes issue >= 1 cycle after push.
// Backpressure: wr_rdy drops while the 2-entry write FIFO is full; read grants are combinational, bounded starvation.
module sbox_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           rd_req,
    input  logic [31:0]    rd_addr,
    output logic           rd_gnt,
    output logic           rd_valid,
    output logic [127:0]   rd_data,
    input  logic           wr_req,
    input  logic [1:0]     wr_bank,
    input  logic [6:0]     wr_addr,
    input  logic [63:0]    wr_data,
    output logic           wr_rdy,
    input  logic           host_req,
    input  logic [9:0]     host_addr,
    output logic           host_gnt,
    output logic           host_valid,
    output logic [31:0]    host_data,
    output logic [27:0]    sram_addr,
    output logic [3:0]     sram_we,
    output logic [63:0]    sram_wdata,
    input  logic [255:0]   sram_q,
    output logic           busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_MAX);

    // write FIFO storage, two slots addressed by 1-bit pointers
    logic [1:0][1:0]  fb_q, fb_d;
    logic [1:0][6:0]  fa_q, fa_d;
    logic [1:0][63:0] fd_q, fd_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic [CW-1:0]    wr_wait_q, wr_wait_d;
    logic [CW-1:0]    host_wait_q, host_wait_d;

    logic             s1_rd_q, s1_rd_d;
    logic [3:0]       s1_rd_half_q, s1_rd_half_d;
    logic             s1_host_q, s1_host_d;
    logic [1:0]       s1_host_bank_q, s1_host_bank_d;
    logic             s1_host_half_q, s1_host_half_d;

    logic             rd_valid_q, rd_valid_d;
    logic [127:0]     rd_data_q, rd_data_d;
    logic             host_valid_q, host_valid_d;
    logic [31:0]      host_data_q, host_data_d;

    logic             fifo_ne;
    logic             force_wr;
    logic             force_host;
    logic             hazard;
    logic [1:0]       slot_vld;
    logic             gnt_rd;
    logic             gnt_wr;
    logic             gnt_host;
    logic             push;

    assign fifo_ne    = (count_q != 2'd0);
    assign wr_rdy     = (count_q != 2'd2);
    assign push       = wr_req & wr_rdy;
    assign force_wr   = fifo_ne && (wr_wait_q == WAIT_MAX);
    assign force_host = host_req && (host_wait_q == WAIT_MAX);

    // Only registered entries are compared; a same-cycle push never blocks a read.
    always_comb begin
        hazard   = 1'b0;
        slot_vld = '0;
        for (int s = 0; s < 2; s++) begin
            slot_vld[s] = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(s)));
            if (slot_vld[s] && (rd_addr[int'(fb_q[s]) * 8 + 1 +: 7] == fa_q[s])) begin
                hazard = 1'b1;
            end
        end
    end

    // Gating with rst_l keeps every grant and SRAM control at zero while reset is held.
    always_comb begin
        gnt_rd   = 1'b0;
        gnt_wr   = 1'b0;
        gnt_host = 1'b0;
        if (rst_l) begin
            if (force_wr) begin
                gnt_wr = 1'b1;
            end else if (force_host) begin
                gnt_host = 1'b1;
            end else if (rd_req && !hazard) begin
                gnt_rd = 1'b1;
            end else if (fifo_ne) begin
                gnt_wr = 1'b1;
            end else if (host_req) begin
                gnt_host = 1'b1;
            end
        end
    end

    assign rd_gnt   = gnt_rd;
    assign host_gnt = gnt_host;

    always_comb begin
        sram_addr  = '0;
        sram_we    = '0;
        sram_wdata = '0;
        if (gnt_rd) begin
            sram_addr = {rd_addr[31:25], rd_addr[23:17], rd_addr[15:9], rd_addr[7:1]};
        end else if (gnt_wr) begin
            sram_addr[int'(fb_q[rd_ptr_q]) * 7 +: 7] = fa_q[rd_ptr_q];
            sram_we[fb_q[rd_ptr_q]]                  = 1'b1;
            sram_wdata                               = fd_q[rd_ptr_q];
        end else if (gnt_host) begin
            sram_addr[int'(host_addr[9:8]) * 7 +: 7] = host_addr[7:1];
        end
    end

    always_comb begin
        fb_d     = fb_q;
        fa_d     = fa_q;
        fd_d     = fd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fb_d[wr_ptr_q] = wr_bank;
            fa_d[wr_ptr_q] = wr_addr;
            fd_d[wr_ptr_q] = wr_data;
            wr_ptr_d       = ~wr_ptr_q;
        end
        if (gnt_wr) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, gnt_wr})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Saturating starvation counters; a held host_wait of STARVE_MAX yields to a forced write.
    always_comb begin
        wr_wait_d = wr_wait_q;
        if (!fifo_ne || gnt_wr) begin
            wr_wait_d = '0;
        end else if (wr_wait_q != WAIT_MAX) begin
            wr_wait_d = wr_wait_q + CW'(1);
        end
        host_wait_d = host_wait_q;
        if (!host_req || gnt_host) begin
            host_wait_d = '0;
        end else if (host_wait_q != WAIT_MAX) begin
            host_wait_d = host_wait_q + CW'(1);
        end
    end

    always_comb begin
        s1_rd_d        = gnt_rd;
        s1_rd_half_d   = {rd_addr[24], rd_addr[16], rd_addr[8], rd_addr[0]};
        s1_host_d      = gnt_host;
        s1_host_bank_d = host_addr[9:8];
        s1_host_half_d = host_addr[0];

        rd_valid_d = s1_rd_q;
        rd_data_d  = rd_data_q;
        if (s1_rd_q) begin
            for (int k = 0; k < 4; k++) begin
                rd_data_d[32*k +: 32] = s1_rd_half_q[k] ? sram_q[64*k + 32 +: 32]
                                                        : sram_q[64*k +: 32];
            end
        end

        host_valid_d = s1_host_q;
        host_data_d  = host_data_q;
        if (s1_host_q) begin
            host_data_d = s1_host_half_q ? sram_q[int'(s1_host_bank_q) * 64 + 32 +: 32]
                                         : sram_q[int'(s1_host_bank_q) * 64 +: 32];
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign host_valid = host_valid_q;
    assign host_data  = host_data_q;
    assign busy       = fifo_ne | s1_rd_q | s1_host_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fb_q           <= '0;
            fa_q           <= '0;
            fd_q           <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            wr_wait_q      <= '0;
            host_wait_q    <= '0;
            s1_rd_q        <= 1'b0;
            s1_rd_half_q   <= '0;
            s1_host_q      <= 1'b0;
            s1_host_bank_q <= '0;
            s1_host_half_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            host_valid_q   <= 1'b0;
            host_data_q    <= '0;
        end else begin
            fb_q           <= fb_d;
            fa_q           <= fa_d;
            fd_q           <= fd_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            wr_wait_q      <= wr_wait_d;
            host_wait_q    <= host_wait_d;
            s1_rd_q        <= s1_rd_d;
            s1_rd_half_q   <= s1_rd_half_d;
            s1_host_q      <= s1_host_d;
            s1_host_bank_q <= s1_host_bank_d;
            s1_host_half_q <= s1_host_half_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            host_valid_q   <= host_valid_d;
            host_data_q    <= host_data_d;
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter with a behavioural 4-bank SRAM model.
module tb_sbox_arbiter;
    logic           clk = 1'b0;
    logic           rst_l = 1'b0;
    logic           rd_req = 1'b0;
    logic [31:0]    rd_addr = '0;
    logic           rd_gnt;
    logic           rd_valid;
    logic [127:0]   rd_data;
    logic           wr_req = 1'b0;
    logic [1:0]     wr_bank = '0;
    logic [6:0]     wr_addr = '0;
    logic [63:0]    wr_data = '0;
    logic           wr_rdy;
    logic           host_req = 1'b0;
    logic [9:0]     host_addr = '0;
    logic           host_gnt;
    logic           host_valid;
    logic [31:0]    host_data;
    logic [27:0]    sram_addr;
    logic [3:0]     sram_we;
    logic [63:0]    sram_wdata;
    logic [255:0]   sram_q = '0;
    logic           busy;

    int n_pass = 0;
    int n_tot  = 0;

    logic [63:0] mem [4][128];

    always #5 clk = ~clk;

    sbox_arbiter #(.STARVE_MAX(8)) dut (
        .clk(clk), .rst_l(rst_l),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt), .host_valid(host_valid),
        .host_data(host_data),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_q(sram_q),
        .busy(busy)
    );

    // SRAM model: preloaded while reset is held, one-cycle read latency.
    always @(posedge clk) begin
        if (!rst_l) begin
            for (int k = 0; k < 4; k++)
                for (int w = 0; w < 128; w++)
                    mem[k][w] <= 64'd0;
            for (int k = 0; k < 4; k++)
                mem[k][k] <= {32'hA0000000 | 32'(k), 32'hB0000000 | 32'(k)};
            mem[3][2] <= 64'hC0DE0302_DEAD0302;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sram_we[k]) mem[k][sram_addr[7*k +: 7]] <= sram_wdata;
                sram_q[64*k +: 64] <= mem[k][sram_addr[7*k +: 7]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_req = 1'b0; wr_req = 1'b0; host_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tot++; if ({rd_gnt, rd_valid, host_gnt, host_valid} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {rd_gnt, rd_valid, host_gnt, host_valid}); else n_pass++;
        n_tot++; if ({rd_data, host_data} !== 160'd0) $display("FAIL reset_data: got %h want 0", {rd_data, host_data}); else n_pass++;
        n_tot++; if ({sram_addr, sram_we, sram_wdata} !== 96'd0) $display("FAIL reset_sram: got %h want 0", {sram_addr, sram_we, sram_wdata}); else n_pass++;
        n_tot++; if ({wr_rdy, busy} !== 2'b10) $display("FAIL reset_rdy_busy: got %b want 10", {wr_rdy, busy}); else n_pass++;
        step();
        rst_l = 1'b1;
        step(); step();
        @(negedge clk);
        n_tot++; if ({wr_rdy, busy, rd_valid, host_valid, sram_we} !== 8'b1000_0000) $display("FAIL idle_state: got %b want 10000000", {wr_rdy, busy, rd_valid, host_valid, sram_we}); else n_pass++;
    endtask

    task automatic test_round_read();
        step();
        rd_req = 1'b1; rd_addr = 32'h07050301;
        @(negedge clk);
        n_tot++; if (rd_gnt !== 1'b1) $display("FAIL rr_gnt: got %b want 1", rd_gnt); else n_pass++;
        n_tot++; if (sram_addr !== {7'd3, 7'd2, 7'd1, 7'd0}) $display("FAIL rr_addr: got %h want %h", sram_addr, {7'd3, 7'd2, 7'd1, 7'd0}); else n_pass++;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        n_tot++; if (rd_valid !== 1'b0) $display("FAIL rr_early_valid: got %b want 0", rd_valid); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (rd_valid !== 1'b1) $display("FAIL rr_valid: got %b want 1", rd_valid); else n_pass++;
        n_tot++; if (rd_data !== 128'hA0000003_A0000002_A0000001_A0000000) $display("FAIL rr_data: got %h want A0000003A0000002A0000001A0000000", rd_data); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (rd_valid !== 1'b0) $display("FAIL rr_pulse: got %b want 0", rd_valid); else n_pass++;
        n_tot++; if (rd_data !== 128'hA0000003_A0000002_A0000001_A0000000) $display("FAIL rr_hold: got %h want A0000003A0000002A0000001A0000000", rd_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        rd_req = 1'b1; rd_addr = 32'h07050301;
        step();
        rd_addr = 32'h06040200;
        @(negedge clk);
        n_tot++; if (rd_gnt !== 1'b1) $display("FAIL b2b_gnt2: got %b want 1", rd_gnt); else n_pass++;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        n_tot++; if ({rd_valid, rd_data} !== {1'b1, 128'hA0000003_A0000002_A0000001_A0000000}) $display("FAIL b2b_first: got %b %h want 1 A0000003A0000002A0000001A0000000", rd_valid, rd_data); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if ({rd_valid, rd_data} !== {1'b1, 128'hB0000003_B0000002_B0000001_B0000000}) $display("FAIL b2b_second: got %b %h want 1 B0000003B0000002B0000001B0000000", rd_valid, rd_data); else n_pass++;
        idle(2);
    endtask

    task automatic test_host_read();
        step();
        host_req = 1'b1; host_addr = 10'h305;
        @(negedge clk);
        n_tot++; if (host_gnt !== 1'b1) $display("FAIL host_gnt: got %b want 1", host_gnt); else n_pass++;
        n_tot++; if (sram_addr !== 28'h0400000) $display("FAIL host_addr_lanes: got %h want 0400000", sram_addr); else n_pass++;
        step();
        host_req = 1'b0;
        step();
        @(negedge clk);
        n_tot++; if ({host_valid, host_data} !== {1'b1, 32'hC0DE0302}) $display("FAIL host_data: got %b %h want 1 C0DE0302", host_valid, host_data); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if ({host_valid, host_data} !== {1'b0, 32'hC0DE0302}) $display("FAIL host_pulse_hold: got %b %h want 0 C0DE0302", host_valid, host_data); else n_pass++;
        idle(1);
    endtask

    task automatic test_starvation();
        logic early_bad;
        early_bad = 1'b0;
        step();
        rd_req = 1'b1; rd_addr = 32'h40404040;
        wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 7'h10; wr_data = 64'hDEADBEEF_00000001;
        @(negedge clk);
        n_tot++; if ({rd_gnt, wr_rdy, sram_we} !== 6'b11_0000) $display("FAIL starve_c0: got %b want 110000", {rd_gnt, wr_rdy, sram_we}); else n_pass++;
        for (int c = 1; c <= 8; c++) begin
            step();
            wr_req = 1'b0;
            @(negedge clk);
            if (rd_gnt !== 1'b1 || sram_we !== 4'b0000) early_bad = 1'b1;
        end
        n_tot++; if (early_bad !== 1'b0) $display("FAIL starve_c1_8: got early write or denied read, want rd_gnt=1 we=0"); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if ({rd_gnt, sram_we} !== 5'b0_0001) $display("FAIL starve_force: got gnt=%b we=%b want gnt=0 we=0001", rd_gnt, sram_we); else n_pass++;
        n_tot++; if ({sram_addr, sram_wdata} !== {28'h0000010, 64'hDEADBEEF_00000001}) $display("FAIL starve_wr_bus: got %h %h want 0000010 DEADBEEF00000001", sram_addr, sram_wdata); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if ({rd_gnt, busy} !== 2'b10) $display("FAIL starve_after: got %b want 10", {rd_gnt, busy}); else n_pass++;
        idle(3);
    endtask

    task automatic test_raw_hazard();
        step();
        wr_req = 1'b1; wr_bank = 2'd2; wr_addr = 7'd5; wr_data = 64'h11223344_55667788;
        step();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h000A0000;
        @(negedge clk);
        n_tot++; if (rd_gnt !== 1'b0) $display("FAIL raw_block: got %b want 0", rd_gnt); else n_pass++;
        n_tot++; if ({sram_we, sram_addr[20:14]} !== {4'b0100, 7'd5}) $display("FAIL raw_write: got we=%b lane2=%0d want 0100 5", sram_we, sram_addr[20:14]); else n_pass++;
        step();
        @(negedge clk);
        n_tot++; if (rd_gnt !== 1'b1) $display("FAIL raw_release: got %b want 1", rd_gnt); else n_pass++;
        step();
        rd_req = 1'b0;
        step();
        @(negedge clk);
        n_tot++; if ({rd_valid, rd_data[95:64]} !== {1'b1, 32'h55667788}) $display("FAIL raw_data: got %b %h want 1 55667788", rd_valid, rd_data[95:64]); else n_pass++;
        idle(2);
    endtask

    task automatic test_host_starve();
        logic early_bad;
        early_bad = 1'b0;
        step();
        rd_req = 1'b1; rd_addr = 32'h40404040;
        host_req = 1'b1; host_addr = 10'h305;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if ({host_gnt, rd_gnt} !== 2'b01) early_bad = 1'b1;
            step();
        end
        n_tot++; if (early_bad !== 1'b0) $display("FAIL hstarve_early: host granted or read denied before limit"); else n_pass++;
        @(negedge clk);
        n_tot++; if ({host_gnt, rd_gnt} !== 2'b10) $display("FAIL hstarve_force: got host=%b rd=%b want 1 0", host_gnt, rd_gnt); else n_pass++;
        step();
        host_req = 1'b0;
        idle(3);
    endtask

    task automatic test_full_reset();
        logic seen;
        seen = 1'b0;
        step();
        rd_req = 1'b1; rd_addr = 32'h40404040;
        wr_req = 1'b1; wr_bank = 2'd1; wr_addr = 7'h11; wr_data = 64'h1;
        step();
        wr_addr = 7'h12; wr_data = 64'h2;
        step();
        wr_req = 1'b0;
        @(negedge clk);
        n_tot++; if ({wr_rdy, busy} !== 2'b01) $display("FAIL full_rdy: got rdy=%b busy=%b want 0 1", wr_rdy, busy); else n_pass++;
        #1;
        rst_l = 1'b0;
        #1;
        n_tot++; if ({wr_rdy, busy, rd_valid, rd_gnt} !== 4'b1000) $display("FAIL rst_mid: got %b want 1000", {wr_rdy, busy, rd_valid, rd_gnt}); else n_pass++;
        rd_req = 1'b0;
        step();
        rst_l = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rd_valid || host_valid || sram_we != 4'b0000) seen = 1'b1;
            step();
        end
        n_tot++; if (seen !== 1'b0) $display("FAIL rst_no_pulse: got activity after release want none"); else n_pass++;
        n_tot++; if ({wr_rdy, busy} !== 2'b10) $display("FAIL rst_after: got %b want 10", {wr_rdy, busy}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_read();
        test_back_to_back();
        test_host_read();
        test_starvation();
        test_raw_hazard();
        test_host_starve();
        test_full_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
